// File: rtl/decode_stage_if.sv
// decode_stage_if: bundles the fetch->decode, decode->execute, branch,
// register-file read and hazard/forwarding signals of the decode stage.
// The master modport is the decode stage; the slave modport is the
// surrounding pipeline (fetch, execute, memory, writeback, register file).
interface decode_stage_if;
    logic         fs_to_ds_valid;
    logic [63:0]  fs_to_ds_bus;
    logic         ds_allowin;
    logic [32:0]  br_bus;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [147:0] ds_to_es_bus;
    logic [4:0]   rf_raddr1;
    logic [4:0]   rf_raddr2;
    logic [31:0]  rf_rdata1;
    logic [31:0]  rf_rdata2;
    logic [4:0]   es_dest;
    logic [4:0]   ms_dest;
    logic [4:0]   ws_dest;
    logic         es_load;
    logic [31:0]  es_fwd;
    logic [31:0]  ms_fwd;
    logic [31:0]  ws_fwd;

    modport master (
        input  fs_to_ds_valid, fs_to_ds_bus, es_allowin, rf_rdata1, rf_rdata2,
               es_dest, ms_dest, ws_dest, es_load, es_fwd, ms_fwd, ws_fwd,
        output ds_allowin, br_bus, ds_to_es_valid, ds_to_es_bus, rf_raddr1, rf_raddr2
    );

    modport slave (
        output fs_to_ds_valid, fs_to_ds_bus, es_allowin, rf_rdata1, rf_rdata2,
               es_dest, ms_dest, ws_dest, es_load, es_fwd, ms_fwd, ws_fwd,
        input  ds_allowin, br_bus, ds_to_es_valid, ds_to_es_bus, rf_raddr1, rf_raddr2
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: MIPS-subset decode stage of a five-stage pipeline.
// Holds one fetched instruction, reads the register file, resolves
// branches/jumps and builds the operand bundle for the execute stage.
// Build option: define DS_FORWARD_EN to forward es/ms/ws results (only a
// load in execute stalls); otherwise any pending write to a used source
// register stalls until it retires.
module decode_stage (
    input  logic           clk,
    input  logic           reset,
    decode_stage_if.master ds_if
);
    logic        ds_valid_r;
    logic [63:0] fs_bus_r;
    logic        ds_ready_go_s;
    logic        ds_allowin_s;
    logic        stall_s;

    logic [31:0] inst_s;
    logic [31:0] pc_s;
    logic [31:0] pc_plus4_s;
    logic [5:0]  op_s;
    logic [5:0]  func_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [4:0]  sa_s;
    logic [15:0] imm_s;

    logic inst_addu_s, inst_subu_s, inst_slt_s, inst_sltu_s, inst_and_s;
    logic inst_or_s, inst_xor_s, inst_nor_s, inst_sll_s, inst_srl_s, inst_sra_s;
    logic inst_addiu_s, inst_lui_s, inst_lw_s, inst_sw_s;
    logic inst_beq_s, inst_bne_s, inst_jal_s, inst_jr_s;

    logic        is_shift_s;
    logic        is_r_arith_s;
    logic        gr_we_s;
    logic        rs_used_s;
    logic        rt_used_s;
    logic [11:0] alu_op_s;
    logic [4:0]  dest_s;
    logic [31:0] rs_value_s;
    logic [31:0] rt_value_s;
    logic [31:0] src1_s;
    logic [31:0] src2_s;
    logic [31:0] sext_imm_s;
    logic        br_taken_s;
    logic [31:0] br_target_s;

    logic es_hit_rs_s, ms_hit_rs_s, ws_hit_rs_s;
    logic es_hit_rt_s, ms_hit_rt_s, ws_hit_rt_s;

    assign inst_s     = fs_bus_r[63:32];
    assign pc_s       = fs_bus_r[31:0];
    assign pc_plus4_s = pc_s + 32'd4;
    assign op_s       = inst_s[31:26];
    assign rs_s       = inst_s[25:21];
    assign rt_s       = inst_s[20:16];
    assign rd_s       = inst_s[15:11];
    assign sa_s       = inst_s[10:6];
    assign func_s     = inst_s[5:0];
    assign imm_s      = inst_s[15:0];
    assign sext_imm_s = {{16{imm_s[15]}}, imm_s};

    // Pipeline occupancy: load a new slot whenever downstream lets us move
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ds_valid_r <= 1'b0;
        end else if (ds_allowin_s) begin
            ds_valid_r <= ds_if.fs_to_ds_valid;
        end else begin
            ds_valid_r <= ds_valid_r;
        end
    end

    // Instruction/pc holding register, captured only on an accepted transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_bus_r <= 64'd0;
        end else if (ds_if.fs_to_ds_valid && ds_allowin_s) begin
            fs_bus_r <= ds_if.fs_to_ds_bus;
        end else begin
            fs_bus_r <= fs_bus_r;
        end
    end

    // One flag per supported instruction; unknown encodings leave all clear
    always_comb begin
        inst_addu_s = 1'b0; inst_subu_s = 1'b0; inst_slt_s  = 1'b0; inst_sltu_s = 1'b0;
        inst_and_s  = 1'b0; inst_or_s   = 1'b0; inst_xor_s  = 1'b0; inst_nor_s  = 1'b0;
        inst_sll_s  = 1'b0; inst_srl_s  = 1'b0; inst_sra_s  = 1'b0; inst_jr_s   = 1'b0;
        inst_addiu_s = 1'b0; inst_lui_s = 1'b0; inst_lw_s   = 1'b0; inst_sw_s   = 1'b0;
        inst_beq_s  = 1'b0; inst_bne_s  = 1'b0; inst_jal_s  = 1'b0;
        case (op_s)
            6'h00: begin
                case (func_s)
                    6'h21:   inst_addu_s = 1'b1;
                    6'h23:   inst_subu_s = 1'b1;
                    6'h2a:   inst_slt_s  = 1'b1;
                    6'h2b:   inst_sltu_s = 1'b1;
                    6'h24:   inst_and_s  = 1'b1;
                    6'h25:   inst_or_s   = 1'b1;
                    6'h26:   inst_xor_s  = 1'b1;
                    6'h27:   inst_nor_s  = 1'b1;
                    6'h00:   inst_sll_s  = 1'b1;
                    6'h02:   inst_srl_s  = 1'b1;
                    6'h03:   inst_sra_s  = 1'b1;
                    6'h08:   inst_jr_s   = 1'b1;
                    default: inst_addu_s = 1'b0;
                endcase
            end
            6'h09:   inst_addiu_s = 1'b1;
            6'h0f:   inst_lui_s   = 1'b1;
            6'h23:   inst_lw_s    = 1'b1;
            6'h2b:   inst_sw_s    = 1'b1;
            6'h04:   inst_beq_s   = 1'b1;
            6'h05:   inst_bne_s   = 1'b1;
            6'h03:   inst_jal_s   = 1'b1;
            default: inst_addu_s  = 1'b0;
        endcase
    end

    assign is_shift_s   = inst_sll_s | inst_srl_s | inst_sra_s;
    assign is_r_arith_s = inst_addu_s | inst_subu_s | inst_slt_s | inst_sltu_s |
                          inst_and_s | inst_or_s | inst_xor_s | inst_nor_s;
    assign gr_we_s      = is_r_arith_s | is_shift_s | inst_addiu_s | inst_lui_s |
                          inst_lw_s | inst_jal_s;
    assign rs_used_s    = is_r_arith_s | inst_addiu_s | inst_lw_s | inst_sw_s |
                          inst_beq_s | inst_bne_s | inst_jr_s;
    assign rt_used_s    = is_r_arith_s | is_shift_s | inst_sw_s | inst_beq_s | inst_bne_s;
    assign alu_op_s     = {inst_lui_s, inst_sra_s, inst_srl_s, inst_sll_s,
                           inst_xor_s, inst_or_s, inst_nor_s, inst_and_s,
                           inst_sltu_s, inst_slt_s, inst_subu_s,
                           inst_addu_s | inst_addiu_s | inst_lw_s | inst_sw_s | inst_jal_s};

    // Register 0 is hardwired, so it never matches a producer
    assign es_hit_rs_s = rs_used_s & (rs_s != 5'd0) & (ds_if.es_dest == rs_s);
    assign ms_hit_rs_s = rs_used_s & (rs_s != 5'd0) & (ds_if.ms_dest == rs_s);
    assign ws_hit_rs_s = rs_used_s & (rs_s != 5'd0) & (ds_if.ws_dest == rs_s);
    assign es_hit_rt_s = rt_used_s & (rt_s != 5'd0) & (ds_if.es_dest == rt_s);
    assign ms_hit_rt_s = rt_used_s & (rt_s != 5'd0) & (ds_if.ms_dest == rt_s);
    assign ws_hit_rt_s = rt_used_s & (rt_s != 5'd0) & (ds_if.ws_dest == rt_s);

`ifdef DS_FORWARD_EN
    // Youngest producer wins: execute, then memory, then writeback
    function automatic logic [31:0] fwd_pick(
        input logic        hit_es,
        input logic        hit_ms,
        input logic        hit_ws,
        input logic [31:0] es_val,
        input logic [31:0] ms_val,
        input logic [31:0] ws_val,
        input logic [31:0] rf_val
    );
        if (hit_es) begin
            return es_val;
        end else if (hit_ms) begin
            return ms_val;
        end else if (hit_ws) begin
            return ws_val;
        end else begin
            return rf_val;
        end
    endfunction

    assign stall_s    = ds_valid_r & ds_if.es_load & (es_hit_rs_s | es_hit_rt_s);
    assign rs_value_s = fwd_pick(es_hit_rs_s, ms_hit_rs_s, ws_hit_rs_s, ds_if.es_fwd,
                                 ds_if.ms_fwd, ds_if.ws_fwd, ds_if.rf_rdata1);
    assign rt_value_s = fwd_pick(es_hit_rt_s, ms_hit_rt_s, ws_hit_rt_s, ds_if.es_fwd,
                                 ds_if.ms_fwd, ds_if.ws_fwd, ds_if.rf_rdata2);
`else
    logic unused_fwd_s;
    assign unused_fwd_s = ^{ds_if.es_load, ds_if.es_fwd, ds_if.ms_fwd, ds_if.ws_fwd};
    assign stall_s      = ds_valid_r & (es_hit_rs_s | ms_hit_rs_s | ws_hit_rs_s |
                                        es_hit_rt_s | ms_hit_rt_s | ws_hit_rt_s);
    assign rs_value_s   = ds_if.rf_rdata1;
    assign rt_value_s   = ds_if.rf_rdata2;
`endif

    assign ds_ready_go_s = ~stall_s;
    assign ds_allowin_s  = ~ds_valid_r | (ds_ready_go_s & ds_if.es_allowin);

    // Operand selection and destination register
    always_comb begin
        src1_s = rs_value_s;
        src2_s = rt_value_s;
        dest_s = 5'd0;
        if (inst_jal_s) begin
            src1_s = pc_s;
        end else if (is_shift_s) begin
            src1_s = {27'd0, sa_s};
        end else begin
            src1_s = rs_value_s;
        end
        if (inst_jal_s) begin
            src2_s = 32'd8;
        end else if (inst_addiu_s || inst_lw_s || inst_sw_s) begin
            src2_s = sext_imm_s;
        end else if (inst_lui_s) begin
            src2_s = {imm_s, 16'd0};
        end else begin
            src2_s = rt_value_s;
        end
        if (!gr_we_s) begin
            dest_s = 5'd0;
        end else if (inst_jal_s) begin
            dest_s = 5'd31;
        end else if (inst_addiu_s || inst_lui_s || inst_lw_s) begin
            dest_s = rt_s;
        end else begin
            dest_s = rd_s;
        end
    end

    // Branch resolution; the target is forced to zero when not taken
    always_comb begin
        br_taken_s  = 1'b0;
        br_target_s = 32'd0;
        if (ds_valid_r && ds_ready_go_s) begin
            if ((inst_beq_s && (rs_value_s == rt_value_s)) ||
                (inst_bne_s && (rs_value_s != rt_value_s))) begin
                br_taken_s  = 1'b1;
                br_target_s = pc_plus4_s + {sext_imm_s[29:0], 2'b00};
            end else if (inst_jal_s) begin
                br_taken_s  = 1'b1;
                br_target_s = {pc_plus4_s[31:28], inst_s[25:0], 2'b00};
            end else if (inst_jr_s) begin
                br_taken_s  = 1'b1;
                br_target_s = rs_value_s;
            end else begin
                br_taken_s  = 1'b0;
                br_target_s = 32'd0;
            end
        end else begin
            br_taken_s  = 1'b0;
            br_target_s = 32'd0;
        end
    end

    assign ds_if.rf_raddr1      = rs_s;
    assign ds_if.rf_raddr2      = rt_s;
    assign ds_if.ds_allowin     = ds_allowin_s;
    assign ds_if.ds_to_es_valid = ds_valid_r & ds_ready_go_s;
    assign ds_if.br_bus         = {br_taken_s, br_target_s};
    assign ds_if.ds_to_es_bus   = {alu_op_s, inst_lw_s, inst_sw_s, gr_we_s, dest_s,
                                   rt_value_s, src2_s, src1_s, pc_s};
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors for decode_stage. Each issued
// instruction pushes its expected {br_bus, ds_to_es_bus} into a queue;
// a monitor pops and compares whenever execute accepts an instruction.
module tb_decode_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_stage_if tb_if();

    decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .ds_if (tb_if)
    );

    logic [31:0] rf [32];
    assign tb_if.rf_rdata1 = rf[tb_if.rf_raddr1];
    assign tb_if.rf_rdata2 = rf[tb_if.rf_raddr2];

    int checks   = 0;
    int failures = 0;
    logic [180:0] sb_q [$];

    function automatic logic [147:0] mk_bus(
        input logic [11:0] alu_op,
        input logic        rfm,
        input logic        mwe,
        input logic        gwe,
        input logic [4:0]  dest,
        input logic [31:0] rtv,
        input logic [31:0] s2,
        input logic [31:0] s1,
        input logic [31:0] pc
    );
        return {alu_op, rfm, mwe, gwe, dest, rtv, s2, s1, pc};
    endfunction

    task automatic check(input string name, input logic [180:0] act, input logic [180:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Present one instruction and hold it until decode accepts it
    task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic push,
                         input logic [147:0] exp_bus, input logic [32:0] exp_br);
        int n;
        if (push) sb_q.push_back({exp_br, exp_bus});
        tb_if.fs_to_ds_valid = 1'b1;
        tb_if.fs_to_ds_bus   = {inst, pc};
        n = 0;
        while (tb_if.ds_allowin !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check_bit("issue_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        tb_if.fs_to_ds_valid = 1'b0;
    endtask

    task automatic drain();
        tb_if.fs_to_ds_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare every instruction execute accepts
    always @(negedge clk) begin
        if (reset === 1'b0 && tb_if.ds_to_es_valid === 1'b1 && tb_if.es_allowin === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", {tb_if.br_bus, tb_if.ds_to_es_bus}, 181'd0);
            end else begin
                check("sb_out", {tb_if.br_bus, tb_if.ds_to_es_bus}, sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [147:0] exp_s;

    initial begin
        reset = 1'b1;
        tb_if.fs_to_ds_valid = 1'b0;
        tb_if.fs_to_ds_bus   = 64'd0;
        tb_if.es_allowin     = 1'b1;
        tb_if.es_dest        = 5'd0;
        tb_if.ms_dest        = 5'd0;
        tb_if.ws_dest        = 5'd0;
        tb_if.es_load        = 1'b0;
        tb_if.es_fwd         = 32'd0;
        tb_if.ms_fwd         = 32'd0;
        tb_if.ws_fwd         = 32'd0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[1] = 32'd5; rf[2] = 32'd7; rf[4] = 32'h44;
        rf[8] = 32'h88; rf[9] = 32'h99; rf[10] = 32'hAA;

        repeat (2) @(posedge clk);
        #1;
        check_bit("reset_ds_to_es_valid", tb_if.ds_to_es_valid, 1'b0);
        check("reset_br_bus", {148'd0, tb_if.br_bus}, 181'd0);
        check_bit("reset_ds_allowin", tb_if.ds_allowin, 1'b1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Back-to-back decode of every instruction class
        issue(32'h00221821, 32'h100, 1'b1, mk_bus(12'h001, 1'b0, 1'b0, 1'b1, 5'd3,  32'd7, 32'd7, 32'd5, 32'h100), 33'd0);
        issue(32'h00223023, 32'h104, 1'b1, mk_bus(12'h002, 1'b0, 1'b0, 1'b1, 5'd6,  32'd7, 32'd7, 32'd5, 32'h104), 33'd0);
        issue(32'h00225827, 32'h108, 1'b1, mk_bus(12'h020, 1'b0, 1'b0, 1'b1, 5'd11, 32'd7, 32'd7, 32'd5, 32'h108), 33'd0);
        issue(32'h00023900, 32'h10C, 1'b1, mk_bus(12'h100, 1'b0, 1'b0, 1'b1, 5'd7,  32'd7, 32'd7, 32'd4, 32'h10C), 33'd0);
        issue(32'h000267C3, 32'h110, 1'b1, mk_bus(12'h400, 1'b0, 1'b0, 1'b1, 5'd12, 32'd7, 32'd7, 32'd31, 32'h110), 33'd0);
        issue(32'h2428FFFE, 32'h114, 1'b1, mk_bus(12'h001, 1'b0, 1'b0, 1'b1, 5'd8,  32'h88, 32'hFFFFFFFE, 32'd5, 32'h114), 33'd0);
        issue(32'h3C091234, 32'h118, 1'b1, mk_bus(12'h800, 1'b0, 1'b0, 1'b1, 5'd9,  32'h99, 32'h12340000, 32'd0, 32'h118), 33'd0);
        issue(32'h8C2A0008, 32'h11C, 1'b1, mk_bus(12'h001, 1'b1, 1'b0, 1'b1, 5'd10, 32'hAA, 32'd8, 32'd5, 32'h11C), 33'd0);
        issue(32'hAC22FFFC, 32'h120, 1'b1, mk_bus(12'h001, 1'b0, 1'b1, 1'b0, 5'd0,  32'd7, 32'hFFFFFFFC, 32'd5, 32'h120), 33'd0);
        issue(32'h1084FFFF, 32'h1000, 1'b1, mk_bus(12'h000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h44, 32'h44, 32'h44, 32'h1000), {1'b1, 32'h00001000});
        issue(32'h14220003, 32'h2000, 1'b1, mk_bus(12'h000, 1'b0, 1'b0, 1'b0, 5'd0, 32'd7, 32'd7, 32'd5, 32'h2000), {1'b1, 32'h00002010});
        issue(32'h14840003, 32'h3000, 1'b1, mk_bus(12'h000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h44, 32'h44, 32'h44, 32'h3000), 33'd0);
        issue(32'h0C000010, 32'hBFC00000, 1'b1, mk_bus(12'h001, 1'b0, 1'b0, 1'b1, 5'd31, 32'd0, 32'd8, 32'hBFC00000, 32'hBFC00000), {1'b1, 32'hB0000040});
        issue(32'h00200008, 32'h400, 1'b1, mk_bus(12'h000, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd5, 32'h400), {1'b1, 32'h00000005});
        issue(32'hFC221234, 32'h500, 1'b1, mk_bus(12'h000, 1'b0, 1'b0, 1'b0, 5'd0, 32'd7, 32'd7, 32'd5, 32'h500), 33'd0);
        drain();

        // Back-pressure: held bus stays put and the new fetch is refused
        tb_if.es_allowin = 1'b0;
        exp_s = mk_bus(12'h001, 1'b0, 1'b0, 1'b1, 5'd3, 32'd7, 32'd7, 32'd5, 32'h600);
        issue(32'h00221821, 32'h600, 1'b1, exp_s, 33'd0);
        tb_if.fs_to_ds_valid = 1'b1;
        tb_if.fs_to_ds_bus   = {32'h00223023, 32'h604};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_bus", {33'd0, tb_if.ds_to_es_bus}, {33'd0, exp_s});
            check_bit("hold_ds_allowin", tb_if.ds_allowin, 1'b0);
            @(posedge clk); #1;
        end
        tb_if.fs_to_ds_valid = 1'b0;
        tb_if.es_allowin     = 1'b1;
        drain();

        // Stall on a pending producer, then reset mid-stall without a clock edge
        tb_if.es_dest = 5'd1;
        tb_if.es_load = 1'b1;
        issue(32'h00221821, 32'h700, 1'b0, 148'd0, 33'd0);
        @(negedge clk);
        check_bit("stall_ds_to_es_valid", tb_if.ds_to_es_valid, 1'b0);
        check_bit("stall_ds_allowin", tb_if.ds_allowin, 1'b0);
        #1 reset = 1'b1;
        #1;
        check_bit("async_rst_ds_to_es_valid", tb_if.ds_to_es_valid, 1'b0);
        check("async_rst_br_bus", {148'd0, tb_if.br_bus}, 181'd0);
        check_bit("async_rst_ds_allowin", tb_if.ds_allowin, 1'b1);
        #1 reset = 1'b0;
        tb_if.es_dest = 5'd0;
        tb_if.es_load = 1'b0;
        @(posedge clk); #1;
        issue(32'h00223023, 32'h704, 1'b1, mk_bus(12'h002, 1'b0, 1'b0, 1'b1, 5'd6, 32'd7, 32'd7, 32'd5, 32'h704), 33'd0);
        drain();

        // addu $5,$4,$0 with a non-load producer of $4 in execute
        tb_if.es_dest = 5'd4;
        tb_if.es_fwd  = 32'h55;
        tb_if.es_load = 1'b0;
`ifdef DS_FORWARD_EN
        tb_if.ms_dest = 5'd4;
        tb_if.ms_fwd  = 32'h66;
        issue(32'h00802821, 32'h800, 1'b1, mk_bus(12'h001, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0, 32'd0, 32'h55, 32'h800), 33'd0);
        check_bit("fwd_no_stall", tb_if.ds_to_es_valid, 1'b1);
        tb_if.ms_dest = 5'd0;
`else
        issue(32'h00802821, 32'h800, 1'b1, mk_bus(12'h001, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0, 32'd0, 32'h44, 32'h800), 33'd0);
        @(negedge clk);
        check_bit("hazard_es_stall", tb_if.ds_to_es_valid, 1'b0);
        @(posedge clk); #1;
        tb_if.es_dest = 5'd0;
        tb_if.ms_dest = 5'd4;
        @(negedge clk);
        check_bit("hazard_ms_stall", tb_if.ds_to_es_valid, 1'b0);
        @(posedge clk); #1;
        tb_if.ms_dest = 5'd0;
        tb_if.ws_dest = 5'd4;
        @(negedge clk);
        check_bit("hazard_ws_stall", tb_if.ds_to_es_valid, 1'b0);
        @(posedge clk); #1;
        tb_if.ws_dest = 5'd0;
`endif
        tb_if.es_dest = 5'd0;
        drain();
        drain();
        check_bit("sb_empty", sb_q.size() == 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have ports clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1, asynchronous, active-high.
REQ-003 The block SHALL have ports fs_to_ds_valid (input, 1) and fs_to_ds_bus (input, 64); the bus is {inst[31:0], pc[31:0]} from fetch_stage.
REQ-004 The block SHALL have port ds_allowin, output, 1, back-pressure to fetch_stage.
REQ-005 The block SHALL have port br_bus, output, 33, {br_taken, br_target[31:0]} to fetch_stage.
REQ-006 The block SHALL have ports es_allowin (input, 1), ds_to_es_valid (output, 1) and ds_to_es_bus (output, 148).
REQ-007 ds_to_es_bus SHALL be {alu_op[11:0], res_from_mem, mem_we, gr_we, dest[4:0], rt_value[31:0], src2[31:0], src1[31:0], pc[31:0]}.
REQ-008 The block SHALL have ports rf_raddr1 and rf_raddr2 (output, 5) and rf_rdata1 and rf_rdata2 (input, 32); these are combinational register-file reads.
REQ-009 The block SHALL have ports es_dest, ms_dest and ws_dest (input, 5 each, 0 = no write); es_load (input, 1); and es_fwd, ms_fwd and ws_fwd (input, 32 each).

Function
REQ-010 ds_valid SHALL be a register: when ds_allowin=1, ds_valid <= fs_to_ds_valid; the bus register SHALL latch only when fs_to_ds_valid && ds_allowin.
REQ-011 The handshake SHALL be: ds_allowin = !ds_valid || (ds_ready_go && es_allowin); ds_to_es_valid = ds_valid && ds_ready_go; ds_ready_go = !stall.
REQ-012 Decoded instructions SHALL be addu, subu, slt, sltu, and, or, xor, nor, sll, srl, sra, addiu, lui, lw, sw, beq, bne, jal and jr; any other encoding SHALL decode with alu_op=0, gr_we=0, mem_we=0 and br_taken=0.
REQ-013 alu_op SHALL be one-hot with bit order [0] add … [11]: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui; addiu, lw, sw and jal SHALL use add.
REQ-014 Operands SHALL be: rf_raddr1 = inst[25:21] and rf_raddr2 = inst[20:16].
REQ-015 src1 SHALL be pc for jal, zero-extended sa for shifts, and rs otherwise.
REQ-016 src2 SHALL be 8 for jal, sign-extended imm for addiu, lw and sw, imm<<16 for lui, and rt otherwise.
REQ-017 dest SHALL be 31 for jal, rt for addiu, lui and lw, and rd for R-type; dest SHALL be 0 whenever gr_we=0.
REQ-018 br_taken SHALL equal ds_valid && ds_ready_go && (beq&&rs==rt || bne&&rs!=rt || jal || jr).
REQ-019 br_target SHALL be pc+4+(sext(imm)<<2) for beq and bne, {pc_plus4[31:28], inst[25:0], 2'b00} for jal, and the rs value for jr; it SHALL be 0 when br_taken=0.
REQ-020 A source register SHALL count as used only if the instruction reads it; register 0 SHALL never cause a stall or a forward.
REQ-021 Simultaneous matches SHALL be resolved with priority es > ms > ws.

Reset
REQ-022 When reset is asserted, ds_valid SHALL clear to 0 immediately and asynchronously, so ds_to_es_valid=0, br_bus=0 and ds_allowin=1; the bus register SHALL clear to 0.
REQ-023 A reset asserted mid-stall SHALL discard the held instruction; after release the first accepted instruction SHALL be the next one fetched.

Configuration
REQ-024 The macro DS_FORWARD_EN SHALL select the hazard scheme; the forwarding ports SHALL exist in both builds.
REQ-025 With DS_FORWARD_EN defined, stall = ds_valid && es_load && es_dest matches a used source.
REQ-026 With DS_FORWARD_EN defined, other matches SHALL take es_fwd, ms_fwd or ws_fwd (priority per REQ-021) in place of rf_rdata for src1, src2, rt_value and the branch compare.
REQ-027 Without DS_FORWARD_EN, stall SHALL equal ds_valid && any used source matches a nonzero es_dest, ms_dest or ws_dest; the *_fwd ports and es_load SHALL be ignored.

Verification
REQ-028 Directed test: reset pulse mid-cycle -> ds_to_es_valid=0, br_bus=0 and ds_allowin=1 within the same cycle, with no clock edge needed.
REQ-029 Directed test: addu $3,$1,$2 (rf_rdata 5, 7) with es_allowin=1 -> next-cycle bus has src1=5, src2=7, dest=3, alu_op=1, gr_we=1.
REQ-030 Directed test: es_allowin=0 for 3 cycles -> ds_to_es_bus holds unchanged and ds_allowin=0; the fetch bus presented meanwhile is not latched.
REQ-031 Directed test: beq $4,$4,-1 at pc 0x1000 -> br_taken=1 and br_target=0x1000.
REQ-032 Directed test: jal at pc 0xBFC00000 with index 0x10 -> dest=31, src1=0xBFC00000, src2=8 and br_target=0xB0000040.
REQ-033 Directed test: addu $5,$4,$0 with es_dest=4 and es_fwd=0x55 (non-load) -> with DS_FORWARD_EN, src1=0x55 with no stall; without it, a stall until all dest fields differ from 4.
